if_id_skid_stage: RTL and testbench
===================================

IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC width.
REQ-002 SHALL provide parameter ILEN, default 32, instruction width.
REQ-003 SHALL provide parameter SB_W, default 4, sideband width (jump, hazard flags, etc.), minimum 1.
REQ-004 SHALL provide parameter NOP_INSTR, default 32'h00000013, bubble instruction value.
REQ-005 SHALL provide parameter CNT_W, default 16, stall counter width.
REQ-006 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-007 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have: in_valid  in  1  fetch entry valid.
REQ-009 SHALL have: in_ready  out  1  stage can accept an entry.
REQ-010 SHALL have: in_pc  in  XLEN; in_instr  in  ILEN; in_sb  in  SB_W  fetch payload.
REQ-011 SHALL have: flush  in  1  synchronous kill of all held entries.
REQ-012 SHALL have: out_valid  out  1; out_ready  in  1  decode-side handshake.
REQ-013 SHALL have: out_pc  out  XLEN; out_instr  out  ILEN; out_sb  out  SB_W  decode payload.
REQ-014 SHALL have: out_bubble  out  1  high whenever out_valid is low.
REQ-015 SHALL have: cnt_clr  in  1; stall_cnt  out  CNT_W  backpressure cycle counter.

Function
REQ-016 SHALL hold two entries: main register (drives out_*) and skid register; states EMPTY (none), ONE (main only), TWO (main+skid).
REQ-017 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready, both sampled at rising clk.
REQ-018 SHALL drive in_ready = 1 when state is not TWO, directly from registered state, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = 1 in states ONE and TWO.
REQ-020 EMPTY: accept -> ONE, main <= input.
REQ-021 ONE: accept & drain -> ONE, main <= input; accept & !drain -> TWO, skid <= input; !accept & drain -> EMPTY; otherwise hold.
REQ-022 TWO: drain -> ONE, main <= skid; otherwise hold (no accept possible).
REQ-023 SHALL preserve strict FIFO order; no entry duplicated or dropped except by flush.
REQ-024 flush SHALL take priority over all transitions: next state EMPTY; any entry accepted in the flush cycle is discarded.
REQ-025 SHALL drive out_instr = NOP_INSTR and out_sb = 0 whenever out_valid is low; out_pc holds its last value.
REQ-026 Latency: accepted entry in EMPTY appears on out_* the next cycle; throughput one entry/cycle when out_ready is held high.
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid & !out_ready, saturating at 2^CNT_W-1.
REQ-028 cnt_clr SHALL set stall_cnt to 0 next cycle; clear wins over simultaneous increment.
REQ-029 flush SHALL NOT affect stall_cnt.

Reset
REQ-030 rst low SHALL immediately force: state EMPTY, out_valid 0, out_bubble 1, out_pc 0, out_instr NOP_INSTR, out_sb 0, stall_cnt 0, skid contents 0.
REQ-031 in_ready SHALL be 1 during and after reset; first accept occurs on the first rising edge with rst high.
REQ-032 Reset asserted mid-transfer SHALL discard all entries without emitting them.

Verification
REQ-033 Reset: rst low mid-cycle with state TWO -> out_valid 0, out_instr 0x00000013, stall_cnt 0 immediately, in_ready 1.
REQ-034 Streaming: out_ready=1, push pc 0x0,0x4,0x8 back-to-back -> out_pc 0x0,0x4,0x8 on cycles 1,2,3, in_ready never low.
REQ-035 Backpressure: out_ready=0, push 0x100,0x104 -> state TWO, in_ready 0, 0x108 held off; raise out_ready -> 0x100,0x104,0x108 in order, stall_cnt = cycles held.
REQ-036 Flush: state TWO plus in_valid with flush=1 -> next cycle out_valid 0, out_bubble 1, in_ready 1; no flushed pc ever emitted.
REQ-037 Counter: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; cnt_clr with stall active -> 0.
REQ-038 Simultaneous: state ONE, accept & drain same cycle -> state stays ONE, out_pc becomes new pc, in_ready stays 1.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage
// Two-entry skid buffer between instruction fetch and decode. A main register
// drives the decode-side outputs, and a skid register catches one extra entry
// so that in_ready can be driven purely from registered state, with no
// combinational path from out_ready. The entries always leave in the order
// they arrived. A backpressure counter records cycles where decode stalls a
// valid entry.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   fetch entry valid
//   in_ready   stage can accept an entry (low only when both registers are full)
//   in_pc, in_instr, in_sb      fetch payload
//   flush      synchronous kill of all held entries and of any entry offered
//              in the same cycle
//   out_valid  decode entry valid
//   out_ready  decode can take the entry
//   out_pc, out_instr, out_sb   decode payload; instr/sb show a bubble when
//              out_valid is low, pc keeps its last value
//   out_bubble high whenever out_valid is low
//   cnt_clr    clear the stall counter
//   stall_cnt  saturating count of out_valid & !out_ready cycles
module if_id_skid_stage #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              SB_W      = 4,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013,
  parameter int              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [ILEN-1:0]   in_instr,
  input  logic [SB_W-1:0]   in_sb,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_instr,
  output logic [SB_W-1:0]   out_sb,
  output logic              out_bubble,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [XLEN-1:0]   main_pc_q, main_pc_d;
  logic [ILEN-1:0]   main_instr_q, main_instr_d;
  logic [SB_W-1:0]   main_sb_q, main_sb_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [ILEN-1:0]   skid_instr_q, skid_instr_d;
  logic [SB_W-1:0]   skid_sb_q, skid_sb_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic accept;
  logic drain;

  // Handshake outputs depend only on the registered state.
  assign in_ready   = (state_q != ST_TWO);
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_bubble = ~out_valid;
  assign out_pc     = main_pc_q;
  assign out_instr  = out_valid ? main_instr_q : NOP_INSTR;
  assign out_sb     = out_valid ? main_sb_q : {SB_W{1'b0}};
  assign stall_cnt  = stall_cnt_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Next-state and payload movement. The main register always holds the
  // oldest entry; the skid register only ever holds the second one, so a
  // drain from TWO promotes skid into main. A flush empties the stage and
  // drops whatever is offered that cycle; main_pc is left alone so out_pc
  // keeps its last value.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    main_sb_d    = main_sb_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_sb_d    = skid_sb_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
            main_sb_d    = in_sb;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
            main_sb_d    = in_sb;
          end else if (accept) begin
            state_d      = ST_TWO;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
            skid_sb_d    = in_sb;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d      = ST_ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            main_sb_d    = skid_sb_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stall counter: clear beats increment, and it sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= {XLEN{1'b0}};
      main_instr_q <= NOP_INSTR;
      main_sb_q    <= {SB_W{1'b0}};
      skid_pc_q    <= {XLEN{1'b0}};
      skid_instr_q <= {ILEN{1'b0}};
      skid_sb_q    <= {SB_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      main_sb_q    <= main_sb_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_sb_q    <= skid_sb_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage
// Drives if_id_skid_stage with directed sequences followed by random traffic.
// A queue-based model of the stage (at most two entries, oldest at the front)
// predicts every output, and a compare process checks the DUT against it on
// each falling clock edge. Directed sequences also check literal values so the
// model itself is pinned down. A second instance with CNT_W=4 shares the
// inputs to exercise counter saturation.
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  sb;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [3:0]  in_sb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [3:0]  out_sb;
  logic        out_bubble;
  logic        cnt_clr;
  logic [15:0] stall_cnt;

  logic        in_ready4, out_valid4, out_bubble4;
  logic [31:0] out_pc4, out_instr4;
  logic [3:0]  out_sb4;
  logic [3:0]  stall_cnt4;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  entry_t      mq[$];
  logic [31:0] m_last_pc = '0;
  int          m_cnt16 = 0;
  int          m_cnt4  = 0;
  bit          m_acc, m_drn, m_stall;

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_sb(in_sb),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_sb(out_sb),
    .out_bubble(out_bubble),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  if_id_skid_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_instr(in_instr), .in_sb(in_sb),
    .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_pc(out_pc4), .out_instr(out_instr4), .out_sb(out_sb4),
    .out_bubble(out_bubble4),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt4)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Set inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input bit ordy,
                               input bit fl, input bit clr);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {pc[15:0], 16'h0093} ^ 32'h5a000000;
    in_sb     = pc[5:2] ^ 4'h9;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Model: a FIFO of at most two entries; the stage accepts when it holds
  // fewer than two and emits the front entry whenever it holds any.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_last_pc = '0;
      m_cnt16   = 0;
      m_cnt4    = 0;
    end else begin
      m_acc   = in_valid && (mq.size() < 2);
      m_drn   = (mq.size() > 0) && out_ready;
      m_stall = (mq.size() > 0) && !out_ready;
      if (cnt_clr) begin
        m_cnt16 = 0;
        m_cnt4  = 0;
      end else if (m_stall) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (m_drn) void'(mq.pop_front());
        if (m_acc) mq.push_back('{pc: in_pc, instr: in_instr, sb: in_sb});
      end
      if (mq.size() > 0) m_last_pc = mq[0].pc;
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] epc, einstr;
    logic [3:0]  esb;
    ev     = (mq.size() > 0);
    epc    = ev ? mq[0].pc : m_last_pc;
    einstr = ev ? mq[0].instr : NOP;
    esb    = ev ? mq[0].sb : 4'h0;
    checkOutput("out_valid",  64'(out_valid),  64'(ev));
    checkOutput("out_bubble", 64'(out_bubble), 64'(!ev));
    checkOutput("in_ready",   64'(in_ready),   64'(mq.size() < 2));
    checkOutput("out_pc",     64'(out_pc),     64'(epc));
    checkOutput("out_instr",  64'(out_instr),  64'(einstr));
    checkOutput("out_sb",     64'(out_sb),     64'(esb));
    checkOutput("stall_cnt",  64'(stall_cnt),  64'(m_cnt16));
    checkOutput("stall_cnt4", 64'(stall_cnt4), 64'(m_cnt4));
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_sb     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset values
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_bubble", 64'(out_bubble), 64'd1);
    checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
    checkOutput("rst_out_instr", 64'(out_instr), 64'(NOP));
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming: back-to-back pcs appear one cycle after acceptance
    applyStimulus(1, 32'h0, 1, 0, 0);
    checkOutput("stream_pc0", 64'(out_pc), 64'h0);
    checkOutput("stream_rdy0", 64'(in_ready), 64'd1);
    applyStimulus(1, 32'h4, 1, 0, 0);
    checkOutput("stream_pc1", 64'(out_pc), 64'h4);
    checkOutput("stream_rdy1", 64'(in_ready), 64'd1);
    applyStimulus(1, 32'h8, 1, 0, 0);
    checkOutput("stream_pc2", 64'(out_pc), 64'h8);
    checkOutput("stream_rdy2", 64'(in_ready), 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkOutput("stream_drained", 64'(out_valid), 64'd0);
    checkOutput("stream_pc_hold", 64'(out_pc), 64'h8);

    // Backpressure: fill both registers, hold 0x108 off, then release
    applyStimulus(1, 32'h100, 0, 0, 1);
    checkOutput("bp_pc_a", 64'(out_pc), 64'h100);
    applyStimulus(1, 32'h104, 0, 0, 0);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1, 32'h108, 0, 0, 0);
    applyStimulus(1, 32'h108, 0, 0, 0);
    checkOutput("bp_hold_pc", 64'(out_pc), 64'h100);
    checkOutput("bp_cnt", 64'(stall_cnt), 64'd3);
    applyStimulus(1, 32'h108, 1, 0, 0);
    checkOutput("bp_pc_b", 64'(out_pc), 64'h104);
    checkOutput("bp_cnt_after", 64'(stall_cnt), 64'd3);
    applyStimulus(1, 32'h108, 1, 0, 0);
    checkOutput("bp_pc_c", 64'(out_pc), 64'h108);
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkOutput("bp_empty", 64'(out_valid), 64'd0);

    // Flush from TWO with an entry offered in the same cycle
    applyStimulus(1, 32'h200, 0, 0, 0);
    applyStimulus(1, 32'h204, 0, 0, 0);
    applyStimulus(1, 32'h208, 0, 1, 0);
    checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_out_bubble", 64'(out_bubble), 64'd1);
    checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
    checkOutput("fl_out_instr", 64'(out_instr), 64'(NOP));
    checkOutput("fl_out_sb", 64'(out_sb), 64'd0);
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkOutput("fl_stays_empty", 64'(out_valid), 64'd0);

    // Simultaneous accept and drain in ONE
    applyStimulus(1, 32'h300, 0, 0, 0);
    applyStimulus(1, 32'h304, 1, 0, 0);
    checkOutput("sim_pc", 64'(out_pc), 64'h304);
    checkOutput("sim_valid", 64'(out_valid), 64'd1);
    checkOutput("sim_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Counter saturation and clear-with-stall
    applyStimulus(1, 32'h400, 0, 0, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 32'h0, 0, 0, 0);
    checkOutput("cnt4_sat", 64'(stall_cnt4), 64'd15);
    checkOutput("cnt16_20", 64'(stall_cnt), 64'd20);
    applyStimulus(0, 32'h0, 0, 0, 1);
    checkOutput("cnt4_clr", 64'(stall_cnt4), 64'd0);
    checkOutput("cnt16_clr", 64'(stall_cnt), 64'd0);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Asynchronous reset mid-cycle while in TWO
    applyStimulus(1, 32'h500, 0, 0, 0);
    applyStimulus(1, 32'h504, 0, 0, 0);
    checkOutput("pre_rst_full", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_out_instr", 64'(out_instr), 64'h13);
    checkOutput("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_out_pc", 64'(out_pc), 64'd0);
    applyStimulus(0, 32'h0, 1, 0, 0);
    #2;
    rst = 1'b1;
    applyStimulus(1, 32'h600, 1, 0, 0);
    checkOutput("post_rst_pc", 64'(out_pc), 64'h600);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit          v, r, f, c;
      logic [31:0] pc;
      v  = ($urandom_range(0, 99) < 70);
      r  = ($urandom_range(0, 99) < 60);
      f  = ($urandom_range(0, 99) < 4);
      c  = ($urandom_range(0, 99) < 3);
      pc = $urandom & 32'hfffffffc;
      applyStimulus(v, pc, r, f, c);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
